// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: SPI slave test peripheral. Each frame receives a WIDTH-bit
// word on mosi, then returns it on miso either echoed or bit-reversed.
// sck/ss/mosi are oversampled in the system clock domain; all SPI modes are
// selected through CPOL/CPHA.
// Optional build macro SPI_BITREV_STATS_EN adds frame_cnt/abort_cnt counters.
module spi_bitrev_slave #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic             rev_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy
`ifdef SPI_BITREV_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      abort_cnt
`endif
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic          SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_tx_shift;
  logic                   r_miso;
  logic                   r_load;
  logic                   r_rx_valid;
  logic [WIDTH-1:0]       r_rx_data;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;

  logic w_sck, w_ss, w_mosi;
  logic w_rise, w_fall, w_lead, w_trail;
  logic w_sample, w_shift;
  logic w_word_done;

  function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // Synchronise the asynchronous SPI pins; sck history feeds the edge detector.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= SCK_IDLE;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise   = w_sck & ~r_sck_prev;
  assign w_fall   = ~w_sck & r_sck_prev;
  assign w_lead   = (CPOL == 0) ? w_rise : w_fall;
  assign w_trail  = (CPOL == 0) ? w_fall : w_rise;
  assign w_sample = (CPHA == 0) ? w_lead : w_trail;
  assign w_shift  = (CPHA == 0) ? w_trail : w_lead;

  assign w_word_done = (r_state == S_RX) & w_sample & ~w_ss & (r_cnt == LAST);

  // Frame sequencer: ss deassertion overrides everything, including a
  // coincident sample edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b1;
    end else if (w_ss) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_miso  <= 1'b1;
          r_state <= S_RX;
        end
        S_RX: begin
          r_miso <= 1'b1;
          if (w_sample) begin
            r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= S_TX;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_TX: begin
          // The load happens the cycle after the last RX sample, well before
          // the first shift edge given the master's sck timing.
          if (r_load) begin
            r_tx_shift <= rev_en ? f_rev(r_rx_shift) : r_rx_shift;
          end else if (w_shift) begin
            r_miso     <= r_tx_shift[WIDTH-1];
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
          end
          if (w_sample) begin
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= S_RX;
              r_miso  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_miso  <= 1'b1;
        end
      endcase
    end
  end

  // Delay the completion strobe by one cycle so rx_data and the TX load see
  // the fully shifted word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_load <= 1'b0;
    else         r_load <= w_word_done;
  end

  // Publish the received word with a one-cycle valid pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= r_load;
      if (r_load) r_rx_data <= r_rx_shift;
    end
  end

  assign miso     = r_miso;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = (r_state != S_IDLE);

`ifdef SPI_BITREV_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_abort_cnt;
  logic        w_tx_done;
  logic        w_abort;

  assign w_tx_done = (r_state == S_TX) & w_sample & ~w_ss & (r_cnt == LAST);
  assign w_abort   = w_ss & ((r_state == S_RX) | (r_state == S_TX)) & (r_cnt != '0);

  // Saturating counters of completed TX halves and mid-word aborts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_tx_done && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_abort && (r_abort_cnt != '1))   r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave: four instances (modes 0..3, mode 3 at WIDTH=16)
// driven by a bit-level SPI master model, table vectors, hand-written corner
// sequences and randomized frames checked against an arithmetic reference.
module tb_spi_bitrev_slave;

  localparam int HALF = 6;  // sck half period in system clocks (>= SYNC_STAGES+2)

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  sck, ss, mosi, rev_en;
  logic [3:0]  miso, rx_valid, busy;
  logic [31:0] rxd [4];
`ifdef SPI_BITREV_STATS_EN
  logic [15:0] fcnt [4];
  logic [15:0] acnt [4];
`endif

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 3) ? 16 : 8;
    logic [W-1:0] w_rxd;
`ifdef SPI_BITREV_STATS_EN
    logic [15:0] w_fc, w_ac;
    assign fcnt[g] = w_fc;
    assign acnt[g] = w_ac;
`endif
    spi_bitrev_slave #(
      .WIDTH(W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) u_dut (
      .clock(clock), .resetn(resetn), .sck(sck[g]), .ss(ss[g]),
      .mosi(mosi[g]), .miso(miso[g]), .rev_en(rev_en[g]),
      .rx_valid(rx_valid[g]), .rx_data(w_rxd), .busy(busy[g])
`ifdef SPI_BITREV_STATS_EN
      , .frame_cnt(w_fc), .abort_cnt(w_ac)
`endif
    );
    assign rxd[g] = 32'(w_rxd);
  end

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Valid-pulse monitor: cycles high, last data, cycle of each rising edge.
  int          vcount [4] = '{default: 0};
  logic [31:0] vdata  [4] = '{default: 0};
  int unsigned vcyc   [4] = '{default: 0};
  logic [3:0]  prev_v = '0;
  logic        watch_busy = 1'b0;
  int          busy_drop = 0;
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        vcount[i]++;
        vdata[i] = rxd[i];
        if (!prev_v[i]) vcyc[i] = cyc;
      end
    end
    prev_v = rx_valid;
    if (watch_busy && busy[0] !== 1'b1) busy_drop++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int width_of(input int m);
    return (m == 3) ? 16 : 8;
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: the master reads the word unchanged, or with bit order reversed.
  function automatic logic [31:0] model_read(input logic [31:0] word, input int w, input logic rev);
    longint unsigned x, r;
    x = 64'(word & wmask(w));
    r = 0;
    if (!rev) return 32'(x);
    for (int i = 0; i < w; i++) r = r * 2 + ((x >> i) % 2);
    return 32'(r);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Master: shift n bits MSB first, returning the bits read on miso.
  task automatic shift_bits(input int m, input int n, input logic [31:0] bits,
                            output logic [31:0] got, output int unsigned last_samp);
    logic pol, pha;
    pol = (m / 2) != 0;
    pha = (m % 2) != 0;
    got = '0;
    last_samp = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!pha) begin
        mosi[m] = bits[i];
        wait_clk(HALF);
        got = {got[30:0], miso[m]};
        last_samp = cyc;
        sck[m] = ~pol;
        wait_clk(HALF);
        sck[m] = pol;
      end else begin
        sck[m]  = ~pol;
        mosi[m] = bits[i];
        wait_clk(HALF);
        got = {got[30:0], miso[m]};
        last_samp = cyc;
        sck[m] = pol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame(input int m, input logic [31:0] word, input logic [31:0] fill,
                       input logic rev, input logic flip_rev,
                       output logic [31:0] rx_half, output logic [31:0] tx_half,
                       output int unsigned lat);
    int w;
    int unsigned s_rx, s_tx;
    w = width_of(m);
    rev_en[m] = rev;
    shift_bits(m, w, word, rx_half, s_rx);
    if (flip_rev) rev_en[m] = ~rev;
    shift_bits(m, w, fill, tx_half, s_tx);
    lat = vcyc[m] - s_rx;
  endtask

  task automatic ss_low(input int m);
    ss[m] = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_high(input int m);
    wait_clk(HALF);
    ss[m] = 1'b1;
    wait_clk(2 * HALF);
  endtask

  typedef struct {
    int          m;
    logic [31:0] word;
    logic [31:0] fill;
    logic        rev;
    logic [31:0] exp_rx;
    logic [31:0] exp_read;
  } vec_t;

  vec_t        tbl [6];
  int          frames_m [4] = '{default: 0};
  int          aborts_m [4] = '{default: 0};
  logic [31:0] rh, th, word;
  int unsigned lat, s;
  int          v0, m, w, nf, k;
  logic        rev, flip, ab;

  initial begin
    tbl[0] = '{0, 32'h01,   32'hFF,   1'b1, 32'h01,   32'h80};
    tbl[1] = '{0, 32'hA5,   32'h00,   1'b0, 32'hA5,   32'hA5};
    tbl[2] = '{3, 32'h1234, 32'hFFFF, 1'b1, 32'h1234, 32'h2C48};
    tbl[3] = '{1, 32'h3C,   32'h5A,   1'b1, 32'h3C,   32'h3C};
    tbl[4] = '{2, 32'hC1,   32'h00,   1'b1, 32'hC1,   32'h83};
    tbl[5] = '{3, 32'h8001, 32'h0000, 1'b0, 32'h8001, 32'h8001};

    resetn = 1'b0;
    sck    = 4'b1100;
    ss     = 4'hF;
    mosi   = 4'h0;
    rev_en = 4'h0;
    wait_clk(4);
    chk("reset_miso", 32'(miso), 32'hF);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_rxdata", rxd[0], 32'h0);
    resetn = 1'b1;
    wait_clk(4);

    // Table-driven single frames across all modes.
    for (int i = 0; i < 6; i++) begin
      v0 = vcount[tbl[i].m];
      ss_low(tbl[i].m);
      frame(tbl[i].m, tbl[i].word, tbl[i].fill, tbl[i].rev, 1'b0, rh, th, lat);
      ss_high(tbl[i].m);
      frames_m[tbl[i].m]++;
      chk($sformatf("vec%0d_rx_miso_idle", i), rh, wmask(width_of(tbl[i].m)));
      chk($sformatf("vec%0d_read", i), th, tbl[i].exp_read);
      chk($sformatf("vec%0d_pulses", i), 32'(vcount[tbl[i].m] - v0), 32'd1);
      chk($sformatf("vec%0d_rxdata", i), vdata[tbl[i].m], tbl[i].exp_rx);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Two back-to-back frames under one ss assertion.
    v0 = vcount[0];
    ss_low(0);
    watch_busy = 1'b1;
    frame(0, 32'h0F, 32'h00, 1'b1, 1'b0, rh, th, lat);
    chk("b2b_read0", th, 32'hF0);
    chk("b2b_rxdata0", vdata[0], 32'h0F);
    frame(0, 32'h3C, 32'h00, 1'b1, 1'b0, rh, th, lat);
    chk("b2b_read1", th, 32'h3C);
    chk("b2b_rx_miso_idle1", rh, 32'hFF);
    chk("b2b_rxdata1", vdata[0], 32'h3C);
    wait_clk(HALF);
    watch_busy = 1'b0;
    chk("b2b_pulses", 32'(vcount[0] - v0), 32'd2);
    chk("b2b_busy_drops", 32'(busy_drop), 32'd0);
    ss_high(0);
    frames_m[0] += 2;
    chk("b2b_busy_after", 32'(busy[0]), 32'd0);

    // Partial frame aborted by ss, then a full frame.
    v0 = vcount[0];
    ss_low(0);
    rev_en[0] = 1'b1;
    shift_bits(0, 5, 32'h1F, rh, s);
    ss_high(0);
    aborts_m[0]++;
    chk("abort_pulses", 32'(vcount[0] - v0), 32'd0);
    chk("abort_miso", 32'(miso[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_rxdata_kept", rxd[0], 32'h3C);
`ifdef SPI_BITREV_STATS_EN
    chk("abort_cnt", 32'(acnt[0]), 32'(aborts_m[0]));
    chk("frame_cnt_mode0", 32'(fcnt[0]), 32'(frames_m[0]));
`endif
    ss_low(0);
    frame(0, 32'h81, 32'h00, 1'b1, 1'b0, rh, th, lat);
    ss_high(0);
    frames_m[0]++;
    chk("after_abort_read", th, 32'h81);
    chk("after_abort_rxdata", vdata[0], 32'h81);

    // Reset pulse in the middle of TX bit 3.
    ss_low(0);
    rev_en[0] = 1'b1;
    shift_bits(0, 8, 32'h01, rh, s);
    shift_bits(0, 3, 32'h00, th, s);
    mosi[0] = 1'b0;
    wait_clk(4);
    chk("pre_reset_tx_bit3", 32'(miso[0]), 32'd0);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midreset_miso", 32'(miso[0]), 32'd1);
    chk("midreset_busy", 32'(busy[0]), 32'd0);
    chk("midreset_valid", 32'(rx_valid[0]), 32'd0);
    chk("midreset_rxdata", rxd[0], 32'h0);
    ss[0] = 1'b1;
    frames_m = '{default: 0};
    aborts_m = '{default: 0};
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(2 * HALF);
    v0 = vcount[0];
    ss_low(0);
    frame(0, 32'h01, 32'hFF, 1'b1, 1'b0, rh, th, lat);
    ss_high(0);
    frames_m[0]++;
    chk("post_reset_read", th, 32'h80);
    chk("post_reset_rxdata", vdata[0], 32'h01);
    chk("post_reset_pulses", 32'(vcount[0] - v0), 32'd1);

    // Randomized sessions: several frames, late rev_en flips, optional abort.
    for (int it = 0; it < 40; it++) begin
      m  = $urandom_range(0, 3);
      w  = width_of(m);
      nf = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0);
      ss_low(m);
      for (int f = 0; f < nf; f++) begin
        word = $urandom & wmask(w);
        rev  = 1'($urandom_range(0, 1));
        flip = 1'($urandom_range(0, 1));
        v0   = vcount[m];
        frame(m, word, $urandom & wmask(w), rev, flip, rh, th, lat);
        frames_m[m]++;
        chk($sformatf("rnd%0d_m%0d_read", it, m), th, model_read(word, w, rev));
        chk($sformatf("rnd%0d_m%0d_rxdata", it, m), vdata[m], word);
        chk($sformatf("rnd%0d_m%0d_pulses", it, m), 32'(vcount[m] - v0), 32'd1);
      end
      if (ab) begin
        k  = $urandom_range(1, w - 1);
        v0 = vcount[m];
        shift_bits(m, k, $urandom, rh, s);
        ss_high(m);
        aborts_m[m]++;
        chk($sformatf("rnd%0d_abort_pulses", it), 32'(vcount[m] - v0), 32'd0);
        chk($sformatf("rnd%0d_abort_miso", it), 32'(miso[m]), 32'd1);
      end else begin
        ss_high(m);
      end
    end

`ifdef SPI_BITREV_STATS_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stats_frame_cnt_m%0d", i), 32'(fcnt[i]), 32'(frames_m[i]));
      chk($sformatf("stats_abort_cnt_m%0d", i), 32'(acnt[i]), 32'(aborts_m[i]));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
